// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and the per-stage register layout for pipelined_adder.
// Struct fields are sized to MAX_WIDTH; the adder only uses the low WIDTH bits.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    localparam int MAX_WIDTH  = 64;

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 ovf;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_reg_t;

endpackage

// File: rtl/adder_chunk.sv
// Purpose: combinational W-bit add of one operand chunk with carry in/out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         msb_carry_in
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
    // Carry into the top bit, recovered from that bit's own sum.
    assign msb_carry_in = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Purpose: STAGES-deep carry-chunked adder with skewed operands and deskewed sums.
// Latency: STAGES cycles from accept to valid_out; one result per cycle when unstalled.
// Backpressure: global enable adv = ~valid_out | out_ready; in_ready = adv.
// Optional checks: define PIPELINED_ADDER_ASSERT_EN for simulation-only monitors.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             valid_in,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             valid_out,
    input  logic             out_ready
);

    localparam int CW = WIDTH / STAGES;

    stage_reg_t src [STAGES];
    stage_reg_t nxt [STAGES];
    stage_reg_t stg [STAGES];
    logic       adv;

    function automatic stage_reg_t fold_chunk(input stage_reg_t p, input int k,
                                              input logic [CW-1:0] s, input logic co,
                                              input logic msb_ci);
        stage_reg_t r;
        r                  = p;
        r.sum[k*CW +: CW]  = s;
        r.carry            = co;
        r.ovf              = msb_ci ^ co;
        return r;
    endfunction

    assign adv      = ~stg[STAGES-1].valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0] c_sum;
        logic          c_co;
        logic          c_msb;

        if (k == 0) begin : g_src
            assign src[k] = '{valid: valid_in, carry: carry_in, ovf: 1'b0, sum: '0,
                              a: MAX_WIDTH'(a), b: MAX_WIDTH'(b)};
        end else begin : g_src
            assign src[k] = stg[k-1];
        end

        adder_chunk #(.W(CW)) u_chunk (
            .a            (src[k].a[k*CW +: CW]),
            .b            (src[k].b[k*CW +: CW]),
            .carry_in     (src[k].carry),
            .sum          (c_sum),
            .carry_out    (c_co),
            .msb_carry_in (c_msb)
        );

        assign nxt[k] = fold_chunk(src[k], k, c_sum, c_co, c_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) stg[k] <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) stg[k] <= nxt[k];
        end
    end

    // Only the last stage's overflow is meaningful: its chunk holds the MSB.
    assign sum       = stg[STAGES-1].sum[WIDTH-1:0];
    assign carry_out = stg[STAGES-1].carry;
    assign overflow  = stg[STAGES-1].ovf;
    assign valid_out = stg[STAGES-1].valid;

`ifdef PIPELINED_ADDER_ASSERT_EN
    typedef struct {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic             known;
    } ref_t;

    ref_t             ref_q [$];
    ref_t             ref_e;
    logic [WIDTH:0]   ref_full;
    logic             stalled_q;
    logic [WIDTH+2:0] held_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q.delete();
            stalled_q <= 1'b0;
            held_q    <= '0;
        end else begin
            if (valid_in && $isunknown({a, b, carry_in}))
                $error("pipelined_adder: X/Z on operands while valid_in is high");
            if (stalled_q && ({sum, carry_out, overflow, valid_out} !== held_q))
                $error("pipelined_adder: outputs changed while stalled");
            if (valid_out && out_ready) begin
                if (ref_q.size() == 0) begin
                    $error("pipelined_adder: result emitted with nothing accepted");
                end else begin
                    ref_e = ref_q.pop_front();
                    if (ref_e.known && ({sum, carry_out, overflow} !== {ref_e.s, ref_e.co, ref_e.ov}))
                        $error("pipelined_adder: result %0h differs from reference %0h",
                               sum, ref_e.s);
                end
            end
            if (valid_in && in_ready) begin
                ref_full    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
                ref_e.s     = ref_full[WIDTH-1:0];
                ref_e.co    = ref_full[WIDTH];
                ref_e.ov    = (a[WIDTH-1] == b[WIDTH-1]) && (ref_full[WIDTH-1] != a[WIDTH-1]);
                ref_e.known = !$isunknown({a, b, carry_in});
                ref_q.push_back(ref_e);
            end
            stalled_q <= valid_out && !out_ready;
            held_q    <= {sum, carry_out, overflow, valid_out};
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random stimulus for pipelined_adder (WIDTH=16, STAGES=4) against an
// arithmetic reference: a queue of expected results aged by pipeline advances.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         carry_in  = 1'b0;
    logic         valid_in  = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         valid_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           age;
    } exp_t;

    exp_t q [$];

    pipelined_adder dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .valid_out (valid_out),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge.
    task automatic cycle(input logic vi, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ci, input logic ordy);
        logic         ev;
        logic         er;
        logic [W:0]   full;
        exp_t         e;
        valid_in  = vi;
        a         = ia;
        b         = ib;
        carry_in  = ci;
        out_ready = ordy;
        #1;
        ev = (q.size() > 0) && (q[0].age >= S);
        er = !ev || ordy;
        chk("valid_out", {31'd0, valid_out}, {31'd0, ev});
        chk("in_ready", {31'd0, in_ready}, {31'd0, er});
        if (ev) begin
            chk("sum", {16'd0, sum}, {16'd0, q[0].s});
            chk("carry_out", {31'd0, carry_out}, {31'd0, q[0].co});
            chk("overflow", {31'd0, overflow}, {31'd0, q[0].ov});
        end
        if (er) begin
            if (ev) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (vi) begin
                full  = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ci};
                e.s   = full[W-1:0];
                e.co  = full[W];
                e.ov  = (ia[W-1] == ib[W-1]) && (full[W-1] != ia[W-1]);
                e.age = 1;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_carry_out", {31'd0, carry_out}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Wrap to zero with carry out, then latency check via bubbles
        cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Signed overflow cases
        cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        cycle(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Back-to-back results, including a carry across a chunk boundary
        cycle(1'b1, 16'd1, 16'd2, 1'b0, 1'b1);
        cycle(1'b1, 16'd3, 16'd4, 1'b0, 1'b1);
        cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Stall with 5+5 at the output; 9+9 offered but must not be taken
        cycle(1'b1, 16'd5, 16'd5, 1'b0, 1'b1);
        cycle(1'b1, 16'd6, 16'd6, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (3) cycle(1'b1, 16'd9, 16'd9, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Random traffic with random backpressure and carry_in
        repeat (400) begin
            cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        repeat (8) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Reset with two items in flight
        cycle(1'b1, 16'd10, 16'd20, 1'b0, 1'b1);
        cycle(1'b1, 16'd30, 16'd40, 1'b1, 1'b1);
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        q.delete();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        repeat (7) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        // Pipeline still works after the mid-flight reset
        cycle(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
        repeat (6) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
